// File: rtl/varray_pkg.sv
// Shared types and sizing for the virtual-array run packer.
// Run descriptors carry start address, length and the repeated element value.
package varray_pkg;

  localparam int VIRTUAL_ADDR_BITS     = 16;
  localparam int VIRTUAL_ELEMENT_WIDTH = 18;
  // Bounded by the 4-bit write_addr_len; legal range is 1..15.
  localparam int MAX_RUN               = 15;

  typedef logic [VIRTUAL_ADDR_BITS-1:0]     vaddr_t;
  typedef logic [VIRTUAL_ELEMENT_WIDTH-1:0] velem_t;

  typedef struct packed {
    vaddr_t     start;
    logic [3:0] len;
    velem_t     dat;
  } run_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } pack_state_e;

  // Address just past a run, wrapped to the address width.
  function automatic vaddr_t run_end_wrap(input run_t r);
    return r.start + vaddr_t'(r.len);
  endfunction

endpackage

// File: rtl/varray_run_emit.sv
// Output register stage: captures a closed run on the emit strobe and drives
// the virtual array's write port for exactly one cycle per run.
module varray_run_emit
  import varray_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             emit,
  input  run_t                             run,
  output logic                             we,
  output logic [VIRTUAL_ADDR_BITS-1:0]     write_addr,
  output logic [3:0]                       write_addr_len,
  output logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w,
  output logic [VIRTUAL_ADDR_BITS-1:0]     packed_end
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      we             <= 1'b0;
      write_addr     <= '0;
      write_addr_len <= '0;
      dat_w          <= '0;
      packed_end     <= '0;
    end else begin
      we <= emit;
      // Write fields hold their last value between emits.
      if (emit) begin
        write_addr     <= run.start;
        write_addr_len <= run.len;
        dat_w          <= run.dat;
        packed_end     <= run_end_wrap(run);
      end
    end
  end

endmodule

// File: rtl/varray_run_packer.sv
// Coalesces monotonically addressed elements with equal data into runs of up
// to MAX_RUN and emits each closed run as a single virtual-array write.
module varray_run_packer
  import varray_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     in_addr,
  input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_dat,
  input  logic                             flush,
  output logic                             flush_done,
  input  logic                             wr_stall,
  output logic                             we,
  output logic [VIRTUAL_ADDR_BITS-1:0]     write_addr,
  output logic [3:0]                       write_addr_len,
  output logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w,
  output logic                             run_open,
  output logic [VIRTUAL_ADDR_BITS-1:0]     packed_end,
  output logic                             order_err
);

  pack_state_e                 state;
  run_t                        run;
  run_t                        new_run;
  logic [VIRTUAL_ADDR_BITS:0]  run_end;
  logic [VIRTUAL_ADDR_BITS:0]  in_addr_x;
  logic                        accept;
  logic                        flush_go;
  logic                        addr_low;
  logic                        can_extend;
  logic                        emit;

  // Handshake: an element transfers on a rising edge where in_valid && in_ready.
  // in_ready never depends on in_valid; it drops while the writer stalls or a
  // flush is pending, so no accept and no flush ever complete during wr_stall.
  assign in_ready = !wr_stall && !flush;
  assign accept   = in_valid && in_ready;

  // flush stays high through the flush_done cycle; masking on flush_done keeps
  // one request from completing twice.
  assign flush_go = flush && !wr_stall && !flush_done;

  // One extra bit so a run reaching the top of the address space compares above
  // every legal address and can never extend.
  assign run_end    = {1'b0, run.start} + {{(VIRTUAL_ADDR_BITS - 3){1'b0}}, run.len};
  assign in_addr_x  = {1'b0, in_addr};
  assign addr_low   = in_addr_x < run_end;
  assign can_extend = (in_addr_x == run_end) && (in_dat == run.dat) &&
                      (run.len < 4'(MAX_RUN));

  assign new_run = '{start: in_addr, len: 4'd1, dat: in_dat};

  assign emit = (state == ST_ACCUM) &&
                (flush_go || (accept && !addr_low && !can_extend));

  assign run_open = (state == ST_ACCUM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      run        <= '0;
      order_err  <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= flush_go;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            run   <= new_run;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (flush_go) begin
            state <= ST_IDLE;
          end else if (accept) begin
            if (addr_low) begin
              order_err <= 1'b1;
            end else if (can_extend) begin
              run.len <= run.len + 4'd1;
            end else begin
              run <= new_run;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  varray_run_emit u_emit (
    .clk            (clk),
    .reset          (reset),
    .emit           (emit),
    .run            (run),
    .we             (we),
    .write_addr     (write_addr),
    .write_addr_len (write_addr_len),
    .dat_w          (dat_w),
    .packed_end     (packed_end)
  );

endmodule

// File: tb/tb_varray_run_packer.sv
// Directed bench for varray_run_packer: hand-computed writes are queued and
// matched against every we pulse by a negedge monitor.
module tb_varray_run_packer;
  import varray_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  logic [17:0] in_dat;
  logic        flush;
  logic        flush_done;
  logic        wr_stall;
  logic        we;
  logic [15:0] write_addr;
  logic [3:0]  write_addr_len;
  logic [17:0] dat_w;
  logic        run_open;
  logic [15:0] packed_end;
  logic        order_err;

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];
  logic [37:0] mon_e;

  always #5 clk = ~clk;

  varray_run_packer dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_dat         (in_dat),
    .flush          (flush),
    .flush_done     (flush_done),
    .wr_stall       (wr_stall),
    .we             (we),
    .write_addr     (write_addr),
    .write_addr_len (write_addr_len),
    .dat_w          (dat_w),
    .run_open       (run_open),
    .packed_end     (packed_end),
    .order_err      (order_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected run.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(write_addr), 64'(mon_e[37:22]));
        check("wr_len", 64'(write_addr_len), 64'(mon_e[21:18]));
        check("wr_dat", 64'(dat_w), 64'(mon_e[17:0]));
      end
    end
  end

  task automatic expect_write(input logic [15:0] a, input logic [3:0] l, input logic [17:0] d);
    exp_q.push_back({a, l, d});
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send(input logic [15:0] a, input logic [17:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_dat   = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush(input string tag, input logic exp_we);
    logic seen;
    seen  = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (flush_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_flush_done"}, 64'(seen), 64'd1);
    if (seen) check({tag, "_we_with_done"}, 64'(we), 64'(exp_we));
    flush = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_one_pulse"}, 64'(flush_done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_dat   = '0;
    flush    = 1'b0;
    wr_stall = 1'b0;
    apply_reset();

    // Reset values
    check("rst_we", 64'(we), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_run_open", 64'(run_open), 64'd0);
    check("rst_order_err", 64'(order_err), 64'd0);
    check("rst_write_addr", 64'(write_addr), 64'd0);
    check("rst_write_len", 64'(write_addr_len), 64'd0);
    check("rst_dat_w", 64'(dat_w), 64'd0);
    check("rst_packed_end", 64'(packed_end), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Three equal elements coalesce into one run
    expect_write(16'd0, 4'd3, 18'd7);
    send(16'd0, 18'd7);
    check("t1_run_open", 64'(run_open), 64'd1);
    send(16'd1, 18'd7);
    send(16'd2, 18'd7);
    do_flush("t1", 1'b1);
    check("t1_packed_end", 64'(packed_end), 64'd3);
    check("t1_run_closed", 64'(run_open), 64'd0);

    // Twenty equal elements split at MAX_RUN
    expect_write(16'd0, 4'd15, 18'd5);
    expect_write(16'd15, 4'd5, 18'd5);
    for (int i = 0; i < 20; i++) send(16'(i), 18'd5);
    do_flush("t2", 1'b1);
    check("t2_packed_end", 64'(packed_end), 64'd20);

    // Data change and address gap both close runs
    expect_write(16'd0, 4'd1, 18'd1);
    expect_write(16'd1, 4'd1, 18'd2);
    expect_write(16'd5, 4'd2, 18'd2);
    send(16'd0, 18'd1);
    send(16'd1, 18'd2);
    send(16'd5, 18'd2);
    send(16'd6, 18'd2);
    do_flush("t3", 1'b1);
    check("t3_packed_end", 64'(packed_end), 64'd7);
    check("t3_order_err", 64'(order_err), 64'd0);

    // Run reaching the top of the address space cannot extend
    expect_write(16'hFFFE, 4'd2, 18'd1);
    send(16'hFFFE, 18'd1);
    send(16'hFFFF, 18'd1);
    send(16'hFFFF, 18'd1);
    check("ceil_order_err", 64'(order_err), 64'd1);
    do_flush("ceil", 1'b1);
    check("ceil_packed_end_wrap", 64'(packed_end), 64'd0);

    apply_reset();
    check("rst2_order_err", 64'(order_err), 64'd0);

    // Backwards address flags an order error and is dropped
    expect_write(16'd10, 4'd1, 18'd3);
    send(16'd10, 18'd3);
    send(16'd8, 18'd3);
    check("t4_order_err", 64'(order_err), 64'd1);
    do_flush("t4", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t4_order_err_sticky", 64'(order_err), 64'd1);
    apply_reset();
    check("t4_order_err_cleared", 64'(order_err), 64'd0);

    // Flush waits out a stall
    expect_write(16'd0, 4'd1, 18'd4);
    send(16'd0, 18'd4);
    wr_stall = 1'b1;
    flush    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t5_stall_in_ready", 64'(in_ready), 64'd0);
      check("t5_stall_we", 64'(we), 64'd0);
      check("t5_stall_done", 64'(flush_done), 64'd0);
    end
    wr_stall = 1'b0;
    do_flush("t5", 1'b1);
    check("t5_packed_end", 64'(packed_end), 64'd1);

    // Reset mid-run discards the pending run without a write
    send(16'd0, 18'd9);
    send(16'd1, 18'd9);
    check("t6_run_open", 64'(run_open), 64'd1);
    apply_reset();
    check("t6_run_open_after_rst", 64'(run_open), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_write_addr_rst", 64'(write_addr), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
